div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
Request/response front end for the 16/8 sequential divider core (`Top`: CLK, Reset, A[7:0], B[15:0] -> Q[7:0], R[7:0], Done).
- Accepts operand pairs on a valid/ready handshake and screens them for divide-by-zero and 8-bit quotient overflow.
- Sequences the core's reset/start and waits for Done, with a timeout.
- Returns Q/R plus an error code on a valid/ready response channel.
- Sits directly upstream of the core and feeds its A, B and Reset inputs.

Parameters:
- LOAD_CYCLES, 2, cycles div_rst is held high after a request is accepted (>=1).
- TIMEOUT, 64, maximum cycles spent in RUN waiting for div_done (2..255).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request operands valid.
- req_ready  out  1  controller can accept a request.
- req_A  in  8  divisor.
- req_B  in  16  dividend.
- div_rst  out  1  drives core Reset; high = core held/loaded.
- div_A  out  8  drives core A.
- div_B  out  16  drives core B.
- div_Q  in  8  core quotient.
- div_R  in  8  core remainder.
- div_done  in  1  core Done, level.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_Q  out  8  quotient.
- rsp_R  out  8  remainder.
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.

Behaviour:
- Reset state: state=IDLE, cnt=0.
  - div_rst=1, div_A=0, div_B=0.
  - rsp_valid=0, rsp_Q=0, rsp_R=0, rsp_err=00.
  - req_ready=0 while Reset is high; it is 1 from the first edge after Reset deasserts.
- FSM states are IDLE, LOAD, RUN, RESP. All outputs are registered.
- IDLE:
  - req_ready=1 and div_rst=1; the core is held in reset so that a stale Done is cleared.
  - Accept occurs on an edge with req_valid & req_ready. The operands are latched into div_A/div_B.
  - If req_A==0: go to RESP with err=01, Q=R=0. The core is not started.
  - Else if req_B[15:8] >= req_A: the quotient is >8 bits. Go to RESP with err=10, Q=R=0. The core is not started.
  - Otherwise go to LOAD with cnt=0.
- LOAD:
  - div_rst=1 for exactly LOAD_CYCLES cycles, counted by cnt.
  - Then go to RUN with cnt=0 and div_rst=0.
- RUN:
  - div_rst=0 and cnt increments each cycle.
  - div_done=1 sampled at an edge: capture div_Q/div_R, set err=00, go to RESP.
  - cnt==TIMEOUT-1 with div_done=0: set err=11, Q=R=0, go to RESP.
  - If div_done and the timeout coincide, div_done wins.
- RESP:
  - rsp_valid=1, and rsp_Q/rsp_R/rsp_err are held stable until rsp_ready.
  - div_rst returns to 1 on entering RESP.
  - On rsp_valid & rsp_ready go to IDLE; rsp_valid drops on the same edge.
  - req_ready stays 0 until IDLE is re-entered, so there is no bypass. Maximum throughput is one request per (LOAD_CYCLES + core latency + 2) cycles.
- Latency:
  - Error fast path: rsp_valid is high 1 cycle after the accept edge.
  - Normal path: rsp_valid rises 1 cycle after div_done is sampled.
- div_A/div_B are stable from the accept until RESP exit.
- Reset mid-operation, any state: immediate return to reset values and div_rst=1. The pending response is discarded.
- Width rules:
  - Compare req_B[15:8] >= req_A unsigned at 8 bits.
  - cnt is 8 bits and never wraps, because TIMEOUT<=255.

Decomposition:
- Shared package div_pkg holds:
  - state encoding (IDLE/LOAD/RUN/RESP);
  - error codes ERR_OK, ERR_DIVZ, ERR_OVF, ERR_TMO;
  - operand width constants DIVISOR_W=8, DIVIDEND_W=16.
- No sub-module. FSM, counter and screening logic live in one module.
- The bench reuses the existing `Top` core as the downstream device.

Test Plan:
1. Normal: req_B=0x1234, req_A=0x56, rsp_ready=1 -> rsp_Q=0x36, rsp_R=0x10, rsp_err=00. div_rst is high exactly 2 cycles after the accept, then low until done.
2. Divide-by-zero: req_A=0x00, req_B=0x0100 -> rsp_valid one cycle after the accept, rsp_err=01, Q=R=0. div_rst never deasserts.
3. Overflow boundary:
   - req_B=0xFFFF, req_A=0xFF -> rsp_err=10.
   - req_B=0xFEFF, req_A=0xFF -> rsp_err=00, Q=0xFF, R=0xFE.
4. Timeout: stub core with div_done tied 0 -> rsp_err=11 exactly TIMEOUT (64) cycles after RUN entry, Q=R=0.
5. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable and req_ready=0 throughout. Handshake completes on the first cycle rsp_ready=1, and req_ready=1 on the next cycle.
6. Reset mid-RUN: assert Reset 3 cycles into RUN -> rsp_valid never rises and div_rst=1 immediately. A new request after deassertion completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divider issue controller: FSM states, response
// error codes and operand widths.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIVZ = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam int DIVISOR_W  = 8;
  localparam int DIVIDEND_W = 16;

endpackage

// File: rtl/div_issue_ctrl.sv
// Request/response front end for the 16/8 sequential divider core: screens
// operands, sequences the core reset/start, waits for Done with a timeout.
//
// state | meaning
// IDLE  | core held in reset, ready for a request
// LOAD  | core held in reset LOAD_CYCLES cycles with operands applied
// RUN   | core released, waiting for Done or timeout
// RESP  | response valid, held until rsp_ready
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DIVISOR_W-1:0]  req_A,
  input  logic [DIVIDEND_W-1:0] req_B,
  output logic                  div_rst,
  output logic [DIVISOR_W-1:0]  div_A,
  output logic [DIVIDEND_W-1:0] div_B,
  input  logic [DIVISOR_W-1:0]  div_Q,
  input  logic [DIVISOR_W-1:0]  div_R,
  input  logic                  div_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DIVISOR_W-1:0]  rsp_Q,
  output logic [DIVISOR_W-1:0]  rsp_R,
  output logic [1:0]            rsp_err
);

  localparam logic [7:0] LOAD_LAST = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    req_ready_q, req_ready_d;
  logic                    div_rst_q, div_rst_d;
  logic [DIVISOR_W-1:0]    div_a_q, div_a_d;
  logic [DIVIDEND_W-1:0]   div_b_q, div_b_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DIVISOR_W-1:0]    rsp_q_q, rsp_q_d;
  logic [DIVISOR_W-1:0]    rsp_r_q, rsp_r_d;
  logic [1:0]              rsp_err_q, rsp_err_d;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      div_rst_q   <= 1'b1;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= '0;
      rsp_r_q     <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      div_rst_q   <= div_rst_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      rsp_r_q     <= rsp_r_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    div_rst_d   = div_rst_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_q_d     = rsp_q_q;
    rsp_r_d     = rsp_r_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        div_rst_d   = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          div_a_d     = req_A;
          div_b_d     = req_B;
          cnt_d       = '0;
          // Screened requests skip the core and answer on the next cycle.
          if (req_A == '0 || req_B[15:8] >= req_A) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_q_d     = '0;
            rsp_r_d     = '0;
            rsp_err_d   = (req_A == '0) ? ERR_DIVZ : ERR_OVF;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          div_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RUN: begin
        if (div_done) begin
          state_d     = RESP;
          div_rst_d   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_q_d     = div_Q;
          rsp_r_d     = div_R;
          rsp_err_d   = ERR_OK;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = RESP;
          div_rst_d   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_q_d     = '0;
          rsp_r_d     = '0;
          rsp_err_d   = ERR_TMO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = req_ready_q;
  assign div_rst   = div_rst_q;
  assign div_A     = div_a_q;
  assign div_B     = div_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_Q     = rsp_q_q;
  assign rsp_R     = rsp_r_q;
  assign rsp_err   = rsp_err_q;

endmodule
